// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port arbiter (instruction fetch + data) in front of one
//                shared, stalling, single-outstanding memory. Each access is
//                IDLE (arbitrate, latch address) -> ISSUE (one-cycle strobe)
//                -> WAIT (completion, error or timeout) -> IDLE.
//
//  Ports
//    clk, rst                 clock, synchronous active-low reset
//    i_addr, i_rd             fetch request (held until i_done / i_err)
//    i_rdata, i_done,
//    i_stall, i_err           fetch response; i_rdata is zero unless i_done
//    d_addr, d_wdata,
//    d_rd, d_wr               data request (held until d_done / d_err)
//    d_rdata, d_done,
//    d_stall, d_err           data response; d_rdata is zero unless d_done
//    mem_addr, mem_wdata,
//    mem_rd, mem_wr           registered memory command, one-cycle strobes
//    mem_rdata, mem_done,
//    mem_stall, mem_err       memory response (mem_stall is not used)
//
//  Parameter
//    TIMEOUT                  WAIT cycles before a forced error (1..255)
//
//  Build option
//    ARB_ROUND_ROBIN_EN       defined   : ties go to the port not granted last
//                             undefined : ties always go to the data port
//
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    // instruction fetch port
    input  logic [15:0] i_addr,
    input  logic        i_rd,
    output logic [15:0] i_rdata,
    output logic        i_done,
    output logic        i_stall,
    output logic        i_err,
    // data port
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    input  logic        d_rd,
    input  logic        d_wr,
    output logic [15:0] d_rdata,
    output logic        d_done,
    output logic        d_stall,
    output logic        d_err,
    // shared memory
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    input  logic        mem_stall,
    input  logic        mem_err
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_ISSUE_I = 3'd1;
    localparam logic [2:0] c_ISSUE_D = 3'd2;
    localparam logic [2:0] c_WAIT_I  = 3'd3;
    localparam logic [2:0] c_WAIT_D  = 3'd4;

    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    logic [2:0]  r_state;
    logic [7:0]  r_cnt;
    logic [15:0] r_memAddr;
    logic [15:0] r_memWdata;
    logic        r_memRd;
    logic        r_memWr;
    logic        r_illegalErr;

    logic w_inIdle;
    logic w_waitI;
    logic w_waitD;
    logic w_dBoth;
    logic w_dIllegal;
    logic w_iReq;
    logic w_dReq;
    logic w_grantI;
    logic w_grantD;
    logic w_memOk;
    logic w_memFail;
    logic w_unusedStall;

    // The memory's busy indication carries no information the FSM needs.
    assign w_unusedStall = mem_stall;

    assign w_inIdle = (r_state == c_IDLE);
    assign w_waitI  = (r_state == c_WAIT_I);
    assign w_waitD  = (r_state == c_WAIT_D);

    // Read and write together is illegal; the data port then does not compete.
    // Detection is suppressed while the resulting error is being reported so
    // a requester that drops on d_err sees exactly one pulse.
    assign w_dBoth    = d_rd & d_wr;
    assign w_dIllegal = w_inIdle & w_dBoth & ~r_illegalErr;
    assign w_iReq     = i_rd;
    assign w_dReq     = (d_rd | d_wr) & ~w_dBoth;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = data port was granted last, 0 = fetch port was granted last.
    logic r_lastD;
    assign w_grantD = w_dReq & (~w_iReq | ~r_lastD);
`else
    assign w_grantD = w_dReq;
`endif
    assign w_grantI = w_iReq & ~w_grantD;

    // Completion is reported combinationally in the cycle the memory answers.
    // An error overrides a simultaneous done; the timeout only fires when the
    // memory has not answered in that cycle.
    assign w_memOk   = mem_done & ~mem_err;
    assign w_memFail = mem_err | (~mem_done & (r_cnt == c_TIMEOUT));

    // Responses are masked while reset is asserted so an abandoned access
    // never produces a pulse.
    assign i_done  = rst & w_waitI & w_memOk;
    assign i_err   = rst & w_waitI & w_memFail;
    assign d_done  = rst & w_waitD & w_memOk;
    assign d_err   = rst & ((w_waitD & w_memFail) | r_illegalErr);

    assign i_rdata = i_done ? mem_rdata : 16'h0000;
    assign d_rdata = d_done ? mem_rdata : 16'h0000;

    assign i_stall = i_rd & ~i_done & ~i_err;
    assign d_stall = (d_rd | d_wr) & ~d_done & ~d_err;

    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign mem_rd    = r_memRd;
    assign mem_wr    = r_memWr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_IDLE;
            r_cnt        <= 8'd0;
            r_memAddr    <= 16'h0000;
            r_memWdata   <= 16'h0000;
            r_memRd      <= 1'b0;
            r_memWr      <= 1'b0;
            r_illegalErr <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_lastD      <= 1'b0;
`endif
        end else begin
            // Strobes are raised on the IDLE->ISSUE edge and so last exactly
            // the one ISSUE cycle.
            r_memRd      <= 1'b0;
            r_memWr      <= 1'b0;
            r_illegalErr <= w_dIllegal;

            case (r_state)
                c_IDLE: begin
                    if (w_grantD) begin
                        r_memAddr  <= d_addr;
                        r_memWdata <= d_wdata;
                        r_memRd    <= d_rd;
                        r_memWr    <= d_wr;
                        r_state    <= c_ISSUE_D;
`ifdef ARB_ROUND_ROBIN_EN
                        r_lastD    <= 1'b1;
`endif
                    end else if (w_grantI) begin
                        r_memAddr  <= i_addr;
                        r_memRd    <= 1'b1;
                        r_state    <= c_ISSUE_I;
`ifdef ARB_ROUND_ROBIN_EN
                        r_lastD    <= 1'b0;
`endif
                    end
                end
                c_ISSUE_I: begin
                    r_cnt   <= 8'd0;
                    r_state <= c_WAIT_I;
                end
                c_ISSUE_D: begin
                    r_cnt   <= 8'd0;
                    r_state <= c_WAIT_D;
                end
                c_WAIT_I, c_WAIT_D: begin
                    if (w_memOk | w_memFail) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. The bench plays the
//                requesters and the shared memory, and predicts every
//                response from an address-keyed memory model and the
//                arbitration rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int c_TIMEOUT   = 8;
    localparam int c_RSP_DONE  = 0;
    localparam int c_RSP_ERR   = 1;
    localparam int c_RSP_BOTH  = 2;
    localparam int c_RSP_TO    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] i_addr = 16'h0000;
    logic        i_rd = 1'b0;
    logic [15:0] i_rdata;
    logic        i_done, i_stall, i_err;
    logic [15:0] d_addr = 16'h0000;
    logic [15:0] d_wdata = 16'h0000;
    logic        d_rd = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_rdata;
    logic        d_done, d_stall, d_err;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_done = 1'b0;
    logic        mem_stall = 1'b0;
    logic        mem_err = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(c_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_rd(i_rd), .i_rdata(i_rdata),
        .i_done(i_done), .i_stall(i_stall), .i_err(i_err),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rd(d_rd), .d_wr(d_wr),
        .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall), .mem_err(mem_err)
    );

    int nTests = 0;
    int nFail  = 0;

    // Memory contents as seen by the bench-side memory (indexed by the address
    // the DUT presents) and as expected by the requesters (indexed by the
    // address they asked for).
    logic [15:0] memSide [int];
    logic [15:0] refMap  [int];
    bit          lastD = 1'b0;

    function automatic logic [15:0] fillPat(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] memRead(input logic [15:0] a);
        return memSide.exists(int'(a)) ? memSide[int'(a)] : fillPat(a);
    endfunction

    function automatic logic [15:0] refRead(input logic [15:0] a);
        return refMap.exists(int'(a)) ? refMap[int'(a)] : fillPat(a);
    endfunction

    function automatic bit tieWinnerD();
`ifdef ARB_ROUND_ROBIN_EN
        return !lastD;
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkReset(input string tag);
        chk({tag, " mem_addr"}, mem_addr, 16'h0000);
        chk({tag, " mem_wdata"}, mem_wdata, 16'h0000);
        chk({tag, " mem_rd"}, mem_rd, 0);
        chk({tag, " mem_wr"}, mem_wr, 0);
        chk({tag, " i_done"}, i_done, 0);
        chk({tag, " i_err"}, i_err, 0);
        chk({tag, " d_done"}, d_done, 0);
        chk({tag, " d_err"}, d_err, 0);
        chk({tag, " i_rdata"}, i_rdata, 16'h0000);
        chk({tag, " d_rdata"}, d_rdata, 16'h0000);
    endtask

    task automatic chkIdle(input string tag);
        chk({tag, " mem_rd"}, mem_rd, 0);
        chk({tag, " mem_wr"}, mem_wr, 0);
        chk({tag, " i_done"}, i_done, 0);
        chk({tag, " d_done"}, d_done, 0);
        chk({tag, " i_err"}, i_err, 0);
        chk({tag, " d_err"}, d_err, 0);
    endtask

    // Entered at the negedge of the ISSUE cycle for the expected port; returns
    // at the negedge of the following IDLE cycle with that request dropped.
    task automatic serve(input bit expD, input int lat, input int resp, input bit withdraw);
        bit          wr, fire, evDone, evErr;
        logic [15:0] a, wd, rv, expRd, pendAddr, pendData;
        wr = expD & d_wr;
        a  = expD ? d_addr : i_addr;
        wd = d_wdata;
        lastD = expD;
        #1;
        chk("issue mem_rd", mem_rd, !wr);
        chk("issue mem_wr", mem_wr, wr);
        chk("issue mem_addr", mem_addr, a);
        if (wr) chk("issue mem_wdata", mem_wdata, wd);
        chk("issue i_stall", i_stall, i_rd);
        chk("issue d_stall", d_stall, d_rd | d_wr);
        chk("issue i_done", i_done, 0);
        chk("issue d_done", d_done, 0);
        pendAddr = mem_addr;
        pendData = mem_wdata;
        for (int k = 0; k <= c_TIMEOUT; k++) begin
            @(negedge clk);
            fire     = (resp != c_RSP_TO) && (k == lat);
            mem_done = fire && (resp != c_RSP_ERR);
            mem_err  = fire && (resp != c_RSP_DONE);
            if (withdraw && k == 0) begin
                if (expD) begin d_rd = 1'b0; d_wr = 1'b0; end
                else i_rd = 1'b0;
            end
            evDone = fire && (resp == c_RSP_DONE);
            evErr  = (fire && (resp != c_RSP_DONE)) || (resp == c_RSP_TO && k == c_TIMEOUT);
            rv = (evDone && !wr) ? memRead(pendAddr) : 16'($urandom);
            mem_rdata = rv;
            expRd = evDone ? (wr ? rv : refRead(a)) : 16'h0000;
            #1;
            chk("wait mem_rd", mem_rd, 0);
            chk("wait mem_wr", mem_wr, 0);
            if (expD) begin
                chk("d_done", d_done, evDone);
                chk("d_err", d_err, evErr);
                chk("d_rdata", d_rdata, expRd);
                chk("d_stall", d_stall, (d_rd | d_wr) & !(evDone | evErr));
                chk("i_done other", i_done, 0);
                chk("i_err other", i_err, 0);
                chk("i_stall other", i_stall, i_rd);
            end else begin
                chk("i_done", i_done, evDone);
                chk("i_err", i_err, evErr);
                chk("i_rdata", i_rdata, expRd);
                chk("i_stall", i_stall, i_rd & !(evDone | evErr));
                chk("d_done other", d_done, 0);
                chk("d_err other", d_err, 0);
                chk("d_stall other", d_stall, d_rd | d_wr);
            end
            if (evDone && wr) begin
                refMap[int'(a)] = wd;
                memSide[int'(pendAddr)] = pendData;
            end
            if (evDone || evErr) break;
        end
        @(negedge clk);
        mem_done = 1'b0;
        mem_err  = 1'b0;
        if (expD) begin d_rd = 1'b0; d_wr = 1'b0; end
        else i_rd = 1'b0;
    endtask

    task automatic single(input bit isD, input bit wr, input logic [15:0] a, input logic [15:0] wd,
                          input int lat, input int resp, input bit withdraw);
        @(negedge clk);
        if (isD) begin
            d_addr = a; d_wdata = wd; d_wr = wr; d_rd = !wr;
        end else begin
            i_addr = a; i_rd = 1'b1;
        end
        #1;
        chk("request stall", isD ? d_stall : i_stall, 1);
        chk("request mem_rd", mem_rd, 0);
        chk("request mem_wr", mem_wr, 0);
        @(negedge clk);
        serve(isD, lat, resp, withdraw);
        #1;
        chkIdle("after access");
    endtask

    task automatic tie(input bit dWrite, input logic [15:0] ia);
        bit firstD;
        @(negedge clk);
        i_addr = ia; i_rd = 1'b1;
        d_addr = 16'h0020; d_wdata = 16'h1234; d_wr = dWrite; d_rd = !dWrite;
        #1;
        chk("tie i_stall", i_stall, 1);
        chk("tie d_stall", d_stall, 1);
        firstD = tieWinnerD();
        @(negedge clk);
        serve(firstD, 1, c_RSP_DONE, 0);
        #1;
        chkIdle("tie gap");
        chk("tie gap stall", firstD ? i_stall : d_stall, 1);
        @(negedge clk);
        serve(!firstD, 0, c_RSP_DONE, 0);
        #1;
        chkIdle("tie end");
    endtask

    initial begin
        // reset
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chkReset("reset");
        @(negedge clk);
        rst = 1'b1;
        lastD = 1'b0;

        // single fetch, memory answers 3 cycles after the strobe
        memSide[16'h0010] = 16'hBEEF;
        refMap[16'h0010]  = 16'hBEEF;
        single(1'b0, 1'b0, 16'h0010, 16'h0000, 2, c_RSP_DONE, 1'b0);

        // simultaneous requests, twice (second time the data port reads back)
        tie(1'b1, 16'h0040);
        tie(1'b0, 16'h0042);

        // timeout on the data port
        single(1'b1, 1'b0, 16'h0030, 16'h0000, 0, c_RSP_TO, 1'b0);

        // illegal read+write
        @(negedge clk);
        d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0050;
        #1;
        chk("illegal first d_err", d_err, 0);
        chk("illegal first mem_rd", mem_rd, 0);
        chk("illegal first mem_wr", mem_wr, 0);
        @(negedge clk);
        #1;
        chk("illegal d_err", d_err, 1);
        chk("illegal d_done", d_done, 0);
        chk("illegal d_stall", d_stall, 0);
        chk("illegal mem_rd", mem_rd, 0);
        chk("illegal mem_wr", mem_wr, 0);
        @(negedge clk);
        d_rd = 1'b0; d_wr = 1'b0;
        #1;
        chkIdle("illegal after");
        @(negedge clk);
        #1;
        chkIdle("illegal after2");

        // error and done together
        single(1'b1, 1'b0, 16'h0060, 16'h0000, 1, c_RSP_BOTH, 1'b0);
        // plain memory error on fetch
        single(1'b0, 1'b0, 16'h0062, 16'h0000, 3, c_RSP_ERR, 1'b0);
        // request withdrawn mid-access still completes
        single(1'b0, 1'b0, 16'h0064, 16'h0000, 3, c_RSP_DONE, 1'b1);

        // reset during a fetch wait, late mem_done ignored
        @(negedge clk);
        i_addr = 16'h0070; i_rd = 1'b1;
        @(negedge clk);
        #1;
        chk("rst-mid mem_rd", mem_rd, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0; i_rd = 1'b0;
        @(negedge clk);
        rst = 1'b1; mem_done = 1'b1; mem_rdata = 16'hDEAD;
        lastD = 1'b0;
        #1;
        chkReset("rst-mid");
        @(negedge clk);
        mem_done = 1'b0;
        single(1'b0, 1'b0, 16'h0070, 16'h0000, 1, c_RSP_DONE, 1'b0);

        // randomized single-port traffic
        for (int n = 0; n < 30; n++) begin
            bit          isD, wr, wd;
            int          r, resp;
            logic [15:0] a;
            isD = 1'($urandom_range(0, 1));
            wr  = isD && ($urandom_range(0, 1) == 1);
            wd  = ($urandom_range(0, 7) == 0);
            a   = 16'($urandom_range(0, 15)) << 1;
            r   = int'($urandom_range(0, 9));
            resp = (r < 7) ? c_RSP_DONE : (r == 7) ? c_RSP_ERR : (r == 8) ? c_RSP_BOTH : c_RSP_TO;
            single(isD, wr, a, 16'($urandom), int'($urandom_range(0, 6)), resp, wd);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
